// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with a per-owner hold limit.
// Every grant ends with a one-cycle turnaround gap. Hold-limit expiry is flagged by a timeout pulse.
module rr_arb4_ctrl #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0] state_q,    state_d;
  logic [1:0] ptr_q,      ptr_d;
  logic [1:0] gnt_idx_q,  gnt_idx_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q,  timeout_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       arb_go;

  // Search ptr+1, ptr+2, ptr+3, then ptr itself last (k=4 wraps to offset 0).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign arb_go = en & win_found;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (arb_go) begin
          state_d    = S_GRANT;
          ptr_d      = win_idx;
          gnt_idx_d  = win_idx;
          hold_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // Release wins over expiry so a coincident drop never pulses timeout.
        if (!req[gnt_idx_q]) begin
          state_d = S_GAP;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd3;
      gnt_idx_q  <= 2'd3;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy    = (state_q == S_GRANT);
  assign gnt     = busy ? (4'b0001 << gnt_idx_q) : '0;
  assign gnt_idx = gnt_idx_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Self-checking bench for rr_arb4_ctrl: directed scenarios followed by random traffic.
// Both phases are compared against a transaction-level arbitration model.
module tb_rr_arb4_ctrl;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: current/last owner, cycles already held, pending timeout flag.
  int m_owner;
  int m_held;
  bit m_grant;
  bit m_to;

  rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 3;
    m_held  = 0;
    m_grant = 0;
    m_to    = 0;
  endtask

  task automatic model_edge();
    if (m_grant) begin
      m_to = 0;
      if (!req[m_owner]) begin
        m_grant = 0;
      end else if (m_held == MAX_HOLD - 1) begin
        m_grant = 0;
        m_to    = 1;
      end else begin
        m_held++;
      end
    end else begin
      int w;
      m_to = 0;
      w = rr_pick(m_owner, req);
      if (en && w >= 0) begin
        m_owner = w;
        m_grant = 1;
        m_held  = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input string what, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed %b expected %b", tag, what, obs, exp);
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] e_gnt;
    logic [3:0] e_idx;
    e_gnt = m_grant ? (4'b0001 << m_owner) : 4'b0000;
    e_idx = 4'(m_owner);
    chk(tag, "gnt",     gnt,              e_gnt);
    chk(tag, "gnt_idx", {2'b00, gnt_idx}, e_idx);
    chk(tag, "busy",    {3'b000, busy},   {3'b000, m_grant});
    chk(tag, "timeout", {3'b000, timeout}, {3'b000, m_to});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all(tag);
    step(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;
    model_reset();
    #1;
    compare_all("reset");
    chk("reset", "gnt_idx3", {2'b00, gnt_idx}, 4'd3);
    step("reset");
    step("reset");
    rst = 1'b0;

    // All four requesting continuously: 0,1,2,3,0 with timeouts.
    req = 4'b1111; en = 1'b1;
    step("rr_all");
    chk("rr_all", "first", gnt, 4'b0001);
    for (int i = 0; i < 7; i++) step("rr_all");
    step("rr_all");
    chk("rr_all", "to0", {3'b000, timeout}, 4'b0001);
    chk("rr_all", "gap0", gnt, 4'b0000);
    step("rr_all");
    chk("rr_all", "second", gnt, 4'b0010);
    for (int i = 0; i < 26; i++) step("rr_all");
    step("rr_all");
    chk("rr_all", "wrap", gnt, 4'b0001);
    req = 4'b0000;
    step("rr_all");
    step("rr_all");

    // Short request from requester 2, voluntary release.
    req = 4'b0100;
    step("rel");
    chk("rel", "gnt2", gnt, 4'b0100);
    step("rel");
    step("rel");
    req = 4'b0000;
    step("rel");
    chk("rel", "no_to", {3'b000, timeout}, 4'b0000);
    step("rel");
    chk("rel", "idle", {3'b000, busy}, 4'b0000);

    // Wrap-around from ptr=3: requester 0 before 3.
    async_reset("wrap_rst");
    req = 4'b1001;
    step("wrap");
    chk("wrap", "first0", gnt, 4'b0001);
    req = 4'b1000;
    step("wrap");
    step("wrap");
    chk("wrap", "then3", gnt, 4'b1000);
    req = 4'b0000;
    step("wrap");
    step("wrap");

    // Enable gating.
    en = 1'b0; req = 4'b0010;
    for (int i = 0; i < 3; i++) step("en");
    chk("en", "blocked", gnt, 4'b0000);
    en = 1'b1;
    step("en");
    chk("en", "granted", gnt, 4'b0010);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("en");
    chk("en", "kept", {3'b000, busy}, 4'b0001);
    req = 4'b0000;
    step("en");
    step("en");
    en = 1'b1;

    // Asynchronous reset in the middle of a grant.
    req = 4'b0100;
    step("arst");
    step("arst");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("arst");
    chk("arst", "gnt0", gnt, 4'b0000);
    step("arst");
    rst = 1'b0;
    req = 4'b1111;
    step("arst");
    chk("arst", "req0", gnt, 4'b0001);
    req = 4'b0000;
    step("arst");
    step("arst");

    // Release on the last allowed hold cycle.
    req = 4'b0010;
    step("edge");
    for (int i = 0; i < MAX_HOLD - 1; i++) step("edge");
    req = 4'b0000;
    step("edge");
    chk("edge", "no_to", {3'b000, timeout}, 4'b0000);
    chk("edge", "gap",   {3'b000, busy},    4'b0000);
    step("edge");

    // Random traffic with sticky requests so hold expiry is reachable.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
